uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter with a small byte FIFO in front of the serializer.
- Lets on-chip logic queue bytes with a VALID/READY handshake for transmission on the TX pin.
- Counterpart to the project's UART receiver, for a picocom-style host link at 9600 baud on the 12 MHz board clock.
- Back-to-back queued bytes go out with no idle gap between frames.

Parameters:
- BIT_RATE, 9600: serial bit rate in baud.
- CLK_HZ, 12_000_000: CLK frequency in Hz. CYCLES_PER_BIT = CLK_HZ/BIT_RATE, integer-truncated (1250 at defaults). Must be at least 4.
- DEPTH, 4: FIFO depth in bytes. Must be a power of two, at least 2.

Ports:
- CLK  in  1  global system clock; all logic on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low; release is synchronised externally.
- VALID  in  1  producer has a byte on DATA.
- DATA  in  8  byte to send; sampled when VALID && READY.
- READY  out  1  FIFO can accept a byte; equals !full, registered state only.
- TX  out  1  UART serial output; idle high; driven from a flop.
- BUSY  out  1  high while a frame is on the line or the FIFO is non-empty.
- LEVEL  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, any state):
  - TX=1, READY=1, BUSY=0, LEVEL=0.
  - FIFO pointers, bit counter, baud counter and shift register cleared; FSM=IDLE.
  - A frame in flight is abandoned immediately and TX returns high; the partial frame is not resumed.
- Handshake:
  - A byte is written on a rising edge where VALID && READY.
  - VALID with READY=0 is ignored; the producer holds DATA.
  - DATA need not be stable outside the transfer cycle.
- FIFO:
  - Circular buffer with wrap-around pointers of $clog2(DEPTH)+1 bits; full/empty come from an MSB compare.
  - Push and pop in the same cycle leave LEVEL unchanged.
  - READY deasserts on the edge LEVEL reaches DEPTH and reasserts the edge after the first pop from full.
  - When full, no push can coincide with the pop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1. If the FIFO is non-empty, pop the head into the shift register, go to START and zero the baud counter.
  - START: TX=0 for CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX=shift[0], LSB first. Shift right every CYCLES_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: TX=1 for CYCLES_PER_BIT cycles. At the end of the stop bit, if the FIFO is non-empty, pop and go directly to START (no idle cycle); otherwise go to IDLE.
- Baud counter:
  - Counts 0..CYCLES_PER_BIT-1 and restarts on every state change.
  - A bit boundary is the cycle the counter equals CYCLES_PER_BIT-1.
  - Frame length is exactly 10*CYCLES_PER_BIT cycles.
- Latency: byte accepted at edge N into an empty FIFO with the FSM idle → pop at edge N+1 → TX low from edge N+2.
- BUSY = (state != IDLE) || LEVEL != 0, registered.
- DATA changing or VALID held while READY=0 has no effect on a frame in progress.

Decomposition:
- Shared package uart_pkg:
  - tx state enum (IDLE/START/DATA/STOP).
  - function cycles_per_bit(CLK_HZ, BIT_RATE).
  - constants FRAME_BITS=10 and DATA_BITS=8.
  - The receiver adopts the same package.
- Sub-module byte_fifo (DEPTH, 8-bit width, push/pop/full/empty/level) is natural and reusable.
- The serializer FSM stays in uart_tx_fifo.

Test Plan:
- Test parameters: CLK_HZ=1000, BIT_RATE=100, so 10 cycles/bit.
- Reset: hold RST_N=0 → TX=1, READY=1, BUSY=0, LEVEL=0. Assert RST_N mid-frame (cycle 35 of a frame) → TX=1 within the same cycle, LEVEL=0; the next byte sent after release is transmitted intact.
- Single byte 0x55: TX low from edge N+2 for 10 cycles, then bits 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10 cycles. BUSY drops after the stop bit. Checked by a bench sampler at bit centres.
- Burst 0xA5, 0x00, 0xFF, 0x3C presented on consecutive cycles:
  - All four accepted with LEVEL peaking at 3.
  - The serial monitor decodes the same four bytes in order.
  - Gap between stop bit end and next start bit = 0 cycles; total 400 cycles from first start.
- Overflow: hold VALID with 6 bytes while the FSM is busy:
  - READY=0 once LEVEL=4; bytes 6 and on are not taken until the first pop.
  - READY reasserts exactly one edge after the pop.
  - No byte is lost or duplicated; the decoded order matches the input.
- Default parameters 12 MHz/9600: byte 0x0D → each bit lasts exactly 1250 cycles (frame 12500 cycles); received correctly by the existing uart receiver instantiated in the loopback bench.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver: frame geometry,
// the transmit state encoding and the baud divisor helper.
// -----------------------------------------------------------------------------
package uart_pkg;

    // 8N1 framing: one start bit, eight data bits, one stop bit.
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_e;

    // Clock cycles per serial bit, integer-truncated.
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Small synchronous circular FIFO. Pointers carry one extra wrap bit so full
// and empty are told apart by comparing the MSBs; occupancy is the pointer
// difference. The head entry is presented combinationally on data_o.
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset (clears pointers)
//   push_i   in   write data_i on this edge (ignored when full)
//   data_i   in   WIDTH-bit write data
//   pop_i    in   drop the head entry on this edge (ignored when empty)
//   data_o   out  head entry, valid while !empty_o
//   full_o   out  DEPTH entries held
//   empty_o  out  no entries held
//   level_o  out  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,          // power of two, at least 2
    parameter int WIDTH = DATA_BITS
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately left out of reset; the pointers
    // alone define which entries are meaningful, and an unreset array maps to
    // plain RAM or cheap flops.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// 8N1 UART transmitter fed by a byte FIFO. Producers queue bytes with a
// VALID/READY handshake; the serializer drains the FIFO and sends frames
// back to back with no idle time between them.
//
// Ports
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset; abandons any frame in flight
//   VALID  in   producer offers DATA
//   DATA   in   byte to queue, taken on an edge with VALID && READY
//   READY  out  FIFO not full
//   TX     out  serial line, idle high, driven from a flop
//   BUSY   out  registered: frame on the line or bytes queued
//   LEVEL  out  FIFO occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BIT_RATE = 9600,
    parameter int CLK_HZ   = 12_000_000,   // CLK_HZ/BIT_RATE must be at least 4
    parameter int DEPTH    = 4             // power of two, at least 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       VALID,
    input  logic [7:0]                 DATA,
    output logic                       READY,
    output logic                       TX,
    output logic                       BUSY,
    output logic [$clog2(DEPTH):0]     LEVEL
);

    localparam int              CPB      = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int              CW       = $clog2(CPB);
    localparam logic [CW-1:0]   BAUD_MAX = CW'(CPB - 1);
    localparam int              IW       = $clog2(DATA_BITS);
    localparam logic [IW-1:0]   LAST_BIT = IW'(DATA_BITS - 1);

    tx_state_e              state_q;
    logic [CW-1:0]          baud_q;
    logic [IW-1:0]          bit_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   tx_q;
    logic                   busy_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_head;
    logic                   push;
    logic                   pop;
    logic                   bit_end;

    assign READY   = !fifo_full;
    assign push    = VALID && !fifo_full;
    assign bit_end = (baud_q == BAUD_MAX);

    // The head is taken either from idle or at the last cycle of a stop bit;
    // the latter chains frames with no idle cycle in between.
    assign pop = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push),
        .data_i  (DATA),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (LEVEL)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            // TX and BUSY trail the state by one cycle, so both line up with
            // each other and every bit still spans exactly CPB cycles.
            unique case (state_q)
                S_START: tx_q <= 1'b0;
                S_DATA:  tx_q <= shift_q[0];
                default: tx_q <= 1'b1;
            endcase
            busy_q <= (state_q != S_IDLE) || !fifo_empty;

            // Every state change happens on a bit boundary, so wrapping at the
            // boundary also restarts the count in the new state.
            if ((state_q == S_IDLE) || bit_end) baud_q <= '0;
            else                                baud_q <= baud_q + 1'b1;

            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q <= fifo_head;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT) state_q   <= S_STOP;
                        else                       bit_idx_q <= bit_idx_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (!fifo_empty) begin
                            shift_q <= fifo_head;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign TX   = tx_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Scoreboard bench: every byte offered is queued as an expected frame; a
// serial monitor per DUT decodes the TX line, checks the waveform cycle by
// cycle against the expected frame and pops the scoreboard at frame end.
// dut_a runs at 10 cycles/bit, dut_b at the default 1250 cycles/bit.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB_A = 10;
    localparam int CPB_B = 1250;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       valid_a = 1'b0;
    logic [7:0] data_a  = 8'h00;
    logic       ready_a, tx_a, busy_a;
    logic [2:0] level_a;

    logic       valid_b = 1'b0;
    logic [7:0] data_b  = 8'h00;
    logic       ready_b, tx_b, busy_b;
    logic [2:0] level_b;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         starts_a[$];
    int         ends_a[$];
    int         acc[8];
    int         lvl_max;

    uart_tx_fifo #(.BIT_RATE(100), .CLK_HZ(1000), .DEPTH(4)) dut_a (
        .CLK(clk), .RST_N(rst_n), .VALID(valid_a), .DATA(data_a),
        .READY(ready_a), .TX(tx_a), .BUSY(busy_a), .LEVEL(level_a)
    );

    uart_tx_fifo dut_b (
        .CLK(clk), .RST_N(rst_n), .VALID(valid_b), .DATA(data_b),
        .READY(ready_b), .TX(tx_b), .BUSY(busy_b), .LEVEL(level_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial monitor: a frame starts at the first low sample; bit k covers
    // frame cycles k*cpb .. k*cpb+cpb-1 and is decoded at its centre.
    task automatic monitor(input int id, input int cpb);
        bit         active = 0;
        int         c = 0;
        int         wave_err = 0;
        int         k;
        logic [7:0] dec = '0;
        logic [7:0] expb = '0;
        logic       t, eb;
        forever begin
            @(negedge clk);
            t = (id == 0) ? tx_a : tx_b;
            if (!rst_n) begin
                active = 0;
            end else begin
                if (!active && t == 1'b0) begin
                    active   = 1;
                    c        = 0;
                    wave_err = 0;
                    dec      = '0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        expb = '0;
                        $display("FAIL unexpected_frame dut%0d: frame started with empty scoreboard (cycle %0d)", id, cyc);
                    end else begin
                        expb = exp_q[0];
                    end
                    if (id == 0) starts_a.push_back(cyc);
                end else if (active) begin
                    c++;
                end
                if (active) begin
                    k  = c / cpb;
                    eb = (k == 0) ? 1'b0 : (k == FRAME_BITS - 1) ? 1'b1 : expb[k-1];
                    if (t !== eb) wave_err++;
                    if (k >= 1 && k <= DATA_BITS && (c % cpb) == cpb / 2) dec[k-1] = t;
                    if (c == FRAME_BITS * cpb - 1) begin
                        check($sformatf("dut%0d_byte", id), dec, expb);
                        check($sformatf("dut%0d_wave_errs", id), wave_err, 0);
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        if (id == 0) ends_a.push_back(cyc);
                        active = 0;
                    end
                end
            end
        end
    endtask

    // Offer one byte and hold it until a handshake edge; returns the cycle count
    // at the accepting edge.
    task automatic send(input int id, input logic [7:0] b, output int acc_cyc);
        bit acc_ok = 0;
        int w = 0;
        exp_q.push_back(b);
        if (id == 0) begin valid_a = 1'b1; data_a = b; end
        else         begin valid_b = 1'b1; data_b = b; end
        while (!acc_ok && w < 400) begin
            @(negedge clk);
            acc_ok = (id == 0) ? ready_a : ready_b;
            @(posedge clk);
            #1;
            w++;
        end
        acc_cyc = cyc;
        if (!acc_ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout dut%0d: byte 0x%0h not accepted in %0d cycles", id, b, w);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int w = 0;
        while ((exp_q.size() != 0 || busy_a || busy_b) && w < budget) begin
            @(posedge clk);
            w++;
        end
        n_cmp++;
        if (w >= budget) begin
            n_bad++;
            $display("FAIL %s_drain: %0d frames still expected after %0d cycles", name, exp_q.size(), w);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor(0, CPB_A);
            monitor(1, CPB_B);
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx_a, 1);
        check("rst_ready", ready_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_level", level_a, 0);
        check("rst_tx_b", tx_b, 1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single byte 0x55: accept at N, pop at N+1, TX low from N+2
        send(0, 8'h55, acc[0]);
        valid_a = 1'b0;
        @(negedge clk);
        check("lat_level_n", level_a, 1);
        check("lat_tx_n", tx_a, 1);
        @(posedge clk); @(negedge clk);
        check("lat_level_n1", level_a, 0);
        check("lat_tx_n1", tx_a, 1);
        check("lat_busy_n1", busy_a, 1);
        @(posedge clk); @(negedge clk);
        check("lat_tx_n2", tx_a, 0);
        repeat (99) @(posedge clk);
        @(negedge clk);
        check("single_busy_stop", busy_a, 1);
        @(posedge clk); @(negedge clk);
        check("single_busy_done", busy_a, 0);
        wait_drain("single", 300);

        // Burst on consecutive cycles
        @(posedge clk); #1;
        starts_a.delete();
        ends_a.delete();
        lvl_max = 0;
        fork
            begin
                send(0, 8'hA5, acc[0]);
                send(0, 8'h00, acc[1]);
                send(0, 8'hFF, acc[2]);
                send(0, 8'h3C, acc[3]);
                valid_a = 1'b0;
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (int'(level_a) > lvl_max) lvl_max = int'(level_a);
                end
            end
        join
        check("burst_accept_span", acc[3] - acc[0], 3);
        check("burst_level_peak", lvl_max, 3);
        wait_drain("burst", 700);
        check("burst_frames", starts_a.size(), 4);
        if (starts_a.size() == 4 && ends_a.size() == 4) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("burst_gap%0d", i), starts_a[i+1] - ends_a[i] - 1, 0);
            check("burst_total", ends_a[3] - starts_a[0] + 1, 400);
        end

        // Overflow: six bytes offered back to back while the FSM is busy
        @(posedge clk); #1;
        send(0, 8'h11, acc[0]);
        send(0, 8'h22, acc[1]);
        send(0, 8'h33, acc[2]);
        send(0, 8'h44, acc[3]);
        send(0, 8'h55, acc[4]);
        @(negedge clk);
        check("ovf_ready_full", ready_a, 0);
        check("ovf_level_full", level_a, 4);
        check("ovf_fill_span", acc[4] - acc[0], 4);
        send(0, 8'h66, acc[5]);
        @(negedge clk);
        valid_a = 1'b0;
        check("ovf_reaccept", acc[5] - acc[0], 102);
        check("ovf_level_refill", level_a, 4);
        check("ovf_ready_refill", ready_a, 0);
        wait_drain("overflow", 1000);

        // Reset at cycle 35 of a frame (data bit 2 of 0x99 is 0), one byte queued
        @(posedge clk); #1;
        send(0, 8'h99, acc[0]);
        send(0, 8'hC3, acc[1]);
        valid_a = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        check("rst_mid_pre_tx", tx_a, 0);
        check("rst_mid_pre_level", level_a, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx_a, 1);
        check("rst_mid_level", level_a, 0);
        check("rst_mid_ready", ready_a, 1);
        check("rst_mid_busy", busy_a, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mid_hold_tx", tx_a, 1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 8'h5A, acc[0]);
        valid_a = 1'b0;
        wait_drain("post_reset", 300);

        // Default 12 MHz / 9600 instance
        @(posedge clk); #1;
        send(1, 8'h0D, acc[0]);
        valid_b = 1'b0;
        wait_drain("default", 13000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
